booth2_seq_mult: RTL and testbench
==================================

BOOTH2_SEQ_MULT -- requirements
Module: booth2_seq_mult

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits; the product width SHALL be 2N.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the rising edge of clk.
REQ-005 The block SHALL have port in0, input, N bits: multiplicand M, two's complement.
REQ-006 The block SHALL have port in1, input, N bits: multiplier Q, two's complement.
REQ-007 The block SHALL have port out, output, 2N bits: signed product, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking out as valid.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 IDLE SHALL move to CALC on an edge with start=1; IDLE SHALL otherwise hold.
REQ-012 CALC SHALL move to DONE on the edge completing step N; CALC SHALL otherwise hold.
REQ-013 DONE SHALL move to IDLE unconditionally on the next edge.
REQ-014 On the edge that accepts start, the block SHALL perform the following load:
- M is captured from in0, sign-extended to N+1 bits.
- Q is captured from in1.
- Accumulator A (N+1 bits) is cleared to 0.
- q_1 is cleared to 0.
- Step counter is cleared to 0.
REQ-015 While in CALC, each edge SHALL execute one radix-2 Booth step on {Q[0], q_1}:
- 01: A = A + M.
- 10: A = A - M.
- 00 or 11: A unchanged.
REQ-016 After the step operation, {A, Q, q_1} SHALL be arithmetically shifted right by 1 (A MSB replicated) and the counter incremented.
REQ-017 All add/subtract SHALL be performed at N+1 bits so that M = -2^(N-1) negates without overflow.
REQ-018 On the edge executing step N, out SHALL be loaded with the low 2N bits of {A_shifted, Q_shifted}.
REQ-019 Latency SHALL be as follows:
- Start is accepted at edge k.
- out updates at edge k+N.
- done=1 for exactly the cycle between edge k+N and edge k+N+1.
REQ-020 busy SHALL be 1 exactly when the state is CALC or DONE.
REQ-021 done SHALL be 1 exactly when the state is DONE.
REQ-022 start SHALL be ignored in CALC and DONE, and a multiply in progress SHALL be unaffected by it.
REQ-023 in0 and in1 SHALL be ignored except on the accepting edge; operand changes mid-operation SHALL not affect the result.
REQ-024 out SHALL hold its last product until the next completed multiply, and SHALL not change on start acceptance.
REQ-025 Back-to-back operation SHALL be supported: start=1 in the cycle after done is accepted from IDLE, giving a minimum issue interval of N+2 cycles.
REQ-026 The result SHALL equal the exact signed product for all 2^(2N) operand pairs.

Reset
REQ-027 While rst=1, independent of clk, the block SHALL force the following:
- state = IDLE.
- out = 0, busy = 0, done = 0.
- A, Q, M, q_1 and counter = 0.
REQ-028 An rst assertion during CALC or DONE SHALL abort the operation with no done pulse and out = 0.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-030 The bench SHALL cover the following directed scenarios with N=4:
- in0=3, in1=5, start pulse -> out=8'h0F, done one cycle, 4 edges after acceptance.
- in0=-8, in1=-8 -> out=8'h40 (+64); checks N+1-bit negation.
- in0=-8, in1=7 -> out=8'hC8 (-56); then in0=7, in1=-1 -> out=8'hF9 (-7), issued back-to-back.
- start held high throughout, with in0/in1 changed during CALC -> second operation begins only after IDLE is re-entered; first result reflects the original operands.
- rst pulsed at step 2 of 3*5 -> out=0, busy=0, no done pulse; next start for 2*2 -> out=8'h04.
- Exhaustive sweep of all 256 operand pairs -> every out matches the signed reference product.

Source files
------------

// File: rtl/booth2_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: one add/sub-and-shift step per clock,
// N steps per product, with registered out/busy/done.
module booth2_seq_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   in0,
    input  logic [N-1:0]   in1,
    output logic [2*N-1:0] out,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N:0]    a;
    logic [N:0]    m;
    logic [N-1:0]  q;
    logic          q_1;
    logic [CW-1:0] cnt;

    logic [N:0]    sum_c;
    logic [N:0]    a_sh_c;
    logic [N-1:0]  q_sh_c;

    // Booth step at N+1 bits so that negating the most negative M cannot overflow
    always_comb begin
        sum_c = a;
        case ({q[0], q_1})
            2'b01:   sum_c = a + m;
            2'b10:   sum_c = a - m;
            default: sum_c = a;
        endcase
        a_sh_c = {sum_c[N], sum_c[N:1]};
        q_sh_c = {sum_c[0], q[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= {in0[N-1], in0};
                        q     <= in1;
                        a     <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a   <= a_sh_c;
                    q   <= q_sh_c;
                    q_1 <= q[0];
                    cnt <= CW'(cnt + 1'b1);
                    // Last step: publish the shifted result directly
                    if (cnt == CW'(N - 1)) begin
                        out   <= {a_sh_c[N-1:0], q_sh_c};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_seq_mult.sv
// Self-checking bench for booth2_seq_mult (N=4): directed scenarios plus an exhaustive sweep,
// with a queue of expected products/completion cycles checked on every done pulse.
module tb_booth2_seq_mult;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   in0;
    logic [N-1:0]   in1;
    logic [2*N-1:0] out;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t exp_q[$];

    booth2_seq_mult #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in0   (in0),
        .in1   (in1),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic signed [N-1:0] sx;
        logic signed [N-1:0] sy;
        int p;
        sx = x;
        sy = y;
        p  = int'(sx) * int'(sy);
        return (2*N)'(p);
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding, out=%h", cyc, out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e.prod || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL product: out=%h at cycle %0d, required %h at cycle %0d", out, cyc, e.prod, e.cyc);
                end
            end
        end
    end

    // Wait for IDLE, drive start for one edge; returns the acceptance cycle
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input bit push, output int acc);
        int n;
        logic [2*N-1:0] out_before;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL issue_timeout: busy=%b, required 0", busy);
        end
        in0   = x;
        in1   = y;
        start = 1'b1;
        if (push) exp_q.push_back('{ref_prod(x, y), cyc + 1 + N});
        out_before = out;
        @(posedge clk);
        acc = cyc;
        @(negedge clk);
        start = 1'b0;
        checks = checks + 1;
        if (busy !== 1'b1 || out !== out_before) begin
            errors = errors + 1;
            $display("FAIL accept: busy=%b out=%h, required busy=1 out=%h", busy, out, out_before);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL drain_timeout: outstanding=%0d busy=%b, required 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in0   = '0;
        in1   = '0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_state: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int acc;
        issue(4'd3, 4'd5, 1'b1, acc);
        wait_drain();
        checks = checks + 1;
        if (out !== 8'h0F || done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL basic_hold: out=%h done=%b, required 0f/0", out, done);
        end
    endtask

    task automatic test_negation();
        int acc;
        issue(4'b1000, 4'b1000, 1'b1, acc);
        wait_drain();
        checks = checks + 1;
        if (out !== 8'h40) begin
            errors = errors + 1;
            $display("FAIL neg_min: out=%h, required 40", out);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int a1;
        issue(4'b1000, 4'd7, 1'b1, a0);
        issue(4'd7, 4'b1111, 1'b1, a1);
        checks = checks + 1;
        if (a1 - a0 != N + 2) begin
            errors = errors + 1;
            $display("FAIL b2b_interval: interval=%0d, required %0d", a1 - a0, N + 2);
        end
        wait_drain();
        checks = checks + 1;
        if (out !== 8'hF9) begin
            errors = errors + 1;
            $display("FAIL b2b_last: out=%h, required f9", out);
        end
    endtask

    task automatic test_start_held();
        int c;
        @(negedge clk);
        c     = cyc;
        in0   = 4'd6;
        in1   = 4'd3;
        start = 1'b1;
        exp_q.push_back('{ref_prod(4'd6, 4'd3), c + 1 + N});
        @(negedge clk);
        @(negedge clk);
        in0 = 4'b1011;
        in1 = 4'd2;
        exp_q.push_back('{ref_prod(4'b1011, 4'd2), c + 2*N + 3});
        while (cyc < c + N + 3) @(negedge clk);
        start = 1'b0;
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL held_reaccept: busy=%b, required 1", busy);
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        int acc;
        issue(4'd3, 4'd5, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_state: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);
        checks = checks + 1;
        if (out !== 8'h00 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_after: out=%h busy=%b, required 00/0", out, busy);
        end
        issue(4'd2, 4'd2, 1'b1, acc);
        wait_drain();
        checks = checks + 1;
        if (out !== 8'h04) begin
            errors = errors + 1;
            $display("FAIL abort_restart: out=%h, required 04", out);
        end
    endtask

    task automatic test_exhaustive();
        int acc;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue(4'(i), 4'(j), 1'b1, acc);
            end
        end
        wait_drain();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_negation();
        test_back_to_back();
        test_start_held();
        test_reset_abort();
        test_exhaustive();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
